// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data SRAM port arbiter.
//   owner_e          : who receives the SRAM read data in the next cycle
//   STARVE_LIMIT_DEF : default number of consecutive lost conflicts before
//                      the fetch requester is forced to win
package mem_arb_pkg;

    localparam int STARVE_LIMIT_DEF = 3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous SRAM between an instruction-fetch
// requester and a data requester. Grants are combinational in the request
// cycle; the response (rvalid) follows one cycle later, steered by a
// registered owner. Data wins conflicts unless fetch has lost STARVE_LIMIT
// consecutive conflicts.
//   clk, resetn                  : clock, synchronous active-low reset
//   inst_req/addr -> inst_gnt    : fetch request channel
//   inst_rvalid/rdata            : fetch response channel
//   data_req/wen/addr/wdata      : data request channel (wen==0 is a read)
//   data_gnt, data_rvalid/rdata  : data grant and response (reads and writes)
//   sram_en/wen/addr/wdata       : shared SRAM request, zero when idle
//   sram_rdata                   : SRAM read data, one cycle after sram_en
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int              CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    owner_e           r_owner;
    owner_e           w_owner_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             w_starved;
    logic             w_inst_win;

    // Fetch wins when alone, or on a conflict once it has been starved.
    assign w_starved  = (r_starve_cnt == LIMIT);
    assign w_inst_win = inst_req && (!data_req || w_starved);

    // Grants are masked during reset so no SRAM access can be issued.
    assign inst_gnt = resetn && w_inst_win;
    assign data_gnt = resetn && data_req && !w_inst_win;

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (inst_gnt) begin
            sram_en   = 1'b1;
            sram_addr = inst_addr;
        end else if (data_gnt) begin
            sram_en    = 1'b1;
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end
    end

    always_comb begin
        w_owner_nxt  = OWN_NONE;
        w_starve_nxt = r_starve_cnt;
        if (inst_gnt)      w_owner_nxt = OWN_INST;
        else if (data_gnt) w_owner_nxt = OWN_DATA;

        // With inst_req high, a data grant can only be a lost conflict.
        if (inst_gnt || !inst_req)     w_starve_nxt = '0;
        else if (data_gnt && !w_starved) w_starve_nxt = r_starve_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_owner      <= OWN_NONE;
            r_starve_cnt <= '0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    assign inst_rvalid = (r_owner == OWN_INST);
    assign data_rvalid = (r_owner == OWN_DATA);
    assign inst_rdata  = sram_rdata;
    assign data_rdata  = sram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: the driver issues one request set per cycle, checks the
// combinational grant/SRAM outputs against a reference model, and queues the
// expected response; an independent monitor pops and checks responses.
module tb_mem_port_arbiter;

    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_gnt, inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_gnt, data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = '0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model driven only by the DUT's SRAM port (read-first on writes).
    logic [31:0] sram_mem [16];
    // Reference memory updated only from stimulus and the model's winner.
    logic [31:0] ref_mem [16];

    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= sram_mem[sram_addr[5:2]];
            for (int b = 0; b < 4; b++)
                if (sram_wen[b]) sram_mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    typedef struct {
        int          due;
        bit          is_inst;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    int m_lost = 0;   // consecutive conflicts lost by fetch

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every rvalid must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (inst_rvalid && data_rvalid) begin
            chk("both_rvalid", 1, 0);
        end else if (inst_rvalid || data_rvalid) begin
            if (sb.size() == 0 || sb[0].due != cyc) begin
                chk("unexpected_rvalid", {inst_rvalid, data_rvalid}, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_is_inst", inst_rvalid, e.is_inst);
                chk("rsp_rdata", inst_rvalid ? inst_rdata : data_rdata, e.rdata);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("missing_rvalid", 0, 1);
        end
    end

    task automatic step(input bit rn, input bit ir, input logic [31:0] ia,
                        input bit dr, input logic [3:0] dw,
                        input logic [31:0] da, input logic [31:0] dd);
        bit          eig, edg;
        logic [3:0]  ewen;
        logic [31:0] eaddr, ewd;
        int          idx;
        exp_t        e;
        @(posedge clk); #1;
        resetn = rn; inst_req = ir; inst_addr = ia;
        data_req = dr; data_wen = dw; data_addr = da; data_wdata = dd;

        eig = 0; edg = 0;
        if (rn) begin
            if (ir && (!dr || m_lost == LIM)) eig = 1;
            else if (dr) edg = 1;
        end
        if (!rn || eig || !ir) m_lost = 0;
        else if (edg && m_lost < LIM) m_lost++;

        ewen = '0; eaddr = '0; ewd = '0;
        if (eig) begin
            eaddr = ia;
            idx = int'(ia[5:2]);
            e.due = cyc + 1; e.is_inst = 1; e.rdata = ref_mem[idx];
            sb.push_back(e);
        end else if (edg) begin
            ewen = dw; eaddr = da; ewd = dd;
            idx = int'(da[5:2]);
            e.due = cyc + 1; e.is_inst = 0; e.rdata = ref_mem[idx];
            sb.push_back(e);
            for (int b = 0; b < 4; b++)
                if (dw[b]) ref_mem[idx][8*b +: 8] = dd[8*b +: 8];
        end

        @(negedge clk);
        chk("inst_gnt", inst_gnt, eig);
        chk("data_gnt", data_gnt, edg);
        chk("sram_en", sram_en, eig | edg);
        chk("sram_wen", sram_wen, ewen);
        chk("sram_addr", sram_addr, eaddr);
        chk("sram_wdata", sram_wdata, ewd);
    endtask

    initial begin
        logic [1:0] pat [8];
        for (int i = 0; i < 16; i++) begin
            sram_mem[i] = 32'hA500_0000 | (i * 32'h0000_0101);
            ref_mem[i]  = 32'hA500_0000 | (i * 32'h0000_0101);
        end

        // Reset state
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        chk("reset_inst_rvalid", inst_rvalid, 0);
        chk("reset_data_rvalid", data_rvalid, 0);

        // Fetch-only stream, back to back
        step(1, 1, 32'h00, 0, 0, 0, 0);
        step(1, 1, 32'h04, 0, 0, 0, 0);
        step(1, 1, 32'h08, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Continuous conflict: D,D,D,I,D,D,D,I
        pat = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 32'h10, 1, 0, 32'h20, 0);
            chk("conflict_seq", {inst_gnt, data_gnt}, pat[i]);
        end
        step(1, 0, 0, 0, 0, 0, 0);

        // Data store
        step(1, 0, 0, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("store_data_rvalid", data_rvalid, 1);
        chk("store_inst_rvalid", inst_rvalid, 0);

        // Interleaved fetch, load, fetch
        step(1, 1, 32'h0C, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 32'h100, 0);
        step(1, 1, 32'h14, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Reset in the cycle after a data grant
        step(1, 0, 0, 1, 0, 32'h04, 0);
        step(0, 1, 32'h08, 1, 4'b1111, 32'h08, 32'h1234_5678);
        step(0, 1, 32'h08, 1, 0, 32'h08, 0);
        chk("rst_data_rvalid", data_rvalid, 0);
        chk("rst_inst_rvalid", inst_rvalid, 0);
        // Counter must be zero after release: data wins three times first.
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 32'h18, 1, 0, 32'h1C, 0);
            chk("post_rst_seq", {inst_gnt, data_gnt}, pat[i]);
        end

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            bit rn, ir, dr;
            logic [3:0] dw;
            rn = ($urandom_range(0, 39) != 0);
            ir = ($urandom_range(0, 9) < 7);
            dr = ($urandom_range(0, 9) < 6);
            dw = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            step(rn, ir, 32'($urandom_range(0, 15)) << 2,
                 dr, dw, 32'($urandom_range(0, 15)) << 2, 32'($urandom));
        end
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W, 32, address width
  DATA_W, 32, data width
  STARVE_LIMIT, 3, consecutive lost conflicts before the instruction requester wins
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on rising edge
  resetn  in  1  synchronous, active-low reset
  inst_req  in  1  instruction-fetch read request
  inst_addr  in  ADDR_W  fetch address
  inst_gnt  out  1  fetch request accepted this cycle
  inst_rvalid  out  1  fetch read data valid
  inst_rdata  out  DATA_W  fetch read data
  data_req  in  1  data access request
  data_wen  in  4  byte write enables; 0 means read
  data_addr  in  ADDR_W  data address
  data_wdata  in  DATA_W  store data
  data_gnt  out  1  data request accepted this cycle
  data_rvalid  out  1  data access response, for reads and writes
  data_rdata  out  DATA_W  data read data
  sram_en  out  1  shared SRAM port enable
  sram_wen  out  4  shared SRAM byte write enables
  sram_addr  out  ADDR_W  shared SRAM address
  sram_wdata  out  DATA_W  shared SRAM write data
  sram_rdata  in  DATA_W  shared SRAM read data; valid one cycle after sram_en

Function
REQ-003 The block SHALL share one single-ported synchronous SRAM between the fetch requester and the data requester, with at most one access per cycle.
REQ-004 Grants SHALL be combinational in the request cycle: inst_gnt/data_gnt asserted in the same cycle as the accepted req, never both at once, never without the matching req.
REQ-005 SRAM outputs SHALL be driven from the granted requester: sram_en=1; addr, wdata and wen taken from the winner; inst grant SHALL drive sram_wen=0 and sram_wdata=0.
REQ-006 With no grant, sram_en, sram_wen, sram_addr and sram_wdata SHALL all be 0.
REQ-007 Priority on conflict (both req=1) SHALL go to data, unless the starvation counter equals STARVE_LIMIT, in which case fetch SHALL win.
REQ-008 The starvation counter SHALL increment, saturating at STARVE_LIMIT, on each conflict cycle granted to data.
REQ-009 The starvation counter SHALL clear to 0 on any inst grant or any cycle with inst_req=0.
REQ-010 A response-owner register SHALL hold one of three states, set every cycle from that cycle's grant: NONE (no grant), INST (inst grant), DATA (data grant).
REQ-011 inst_rvalid SHALL be 1 exactly when the owner is INST, one cycle after the inst grant.
REQ-012 data_rvalid SHALL be 1 exactly when the owner is DATA, one cycle after the data grant.
REQ-013 inst_rdata and data_rdata SHALL both pass sram_rdata through unregistered; consumers qualify them with rvalid.
REQ-014 Back-to-back grants SHALL be supported, giving full throughput of one access per cycle and a response one cycle after each grant.
REQ-015 A single requester with no conflict SHALL be granted every cycle it requests, regardless of counter value.

Reset
REQ-016 While resetn=0 at a clock edge: owner SHALL go to NONE and the counter to 0, so that inst_rvalid=0 and data_rvalid=0 in the following cycle.
REQ-017 Grants SHALL be forced to 0 during any cycle with resetn=0, so that no SRAM access is issued.
REQ-018 A response outstanding when reset is applied SHALL be dropped, not delivered after reset.

Structure
REQ-019 Package mem_arb_pkg SHALL hold the owner-state enumeration (NONE, INST, DATA) and the default STARVE_LIMIT constant.
REQ-020 No sub-module is needed: grant logic, owner register and starvation counter SHALL be implemented inline.

Verification
REQ-021 Fetch only, inst_req=1 with addr 0x00, 0x04, 0x08 on consecutive cycles -> inst_gnt=1 each cycle; inst_rvalid=1 on the next three cycles with the SRAM words; data_rvalid=0 throughout.
REQ-022 Continuous conflict, STARVE_LIMIT=3, both req=1 for 8 cycles -> grant sequence D,D,D,I,D,D,D,I.
REQ-023 Data store, data_wen=4'b0011, addr 0x100, wdata 0xDEADBEEF -> same cycle sram_en=1, sram_wen=4'b0011, sram_addr=0x100; next cycle data_rvalid=1 and inst_rvalid=0.
REQ-024 Interleaved fetch, load, fetch on three cycles -> rvalid is routed to fetch, data, fetch on the following three cycles, with no cross-delivery.
REQ-025 Reset mid-operation, resetn=0 in the cycle after a data grant -> data_rvalid=0 next cycle, no grant while resetn=0, counter=0 after release.
